// File: rtl/key_expander_iter.sv
// rtl/key_expander_iter.sv - iterative AES key expander, one schedule word per clock
// Round keys are read combinationally from the word store once key_ready is set.
module key_expander_iter #(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  input  logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         key_ready,
  output logic [127:0] rk_out
);
  localparam int         NWORDS   = 4 * (MAX_NK + 7);
  localparam logic [5:0] NWORDS_W = 6'(NWORDS);
  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

  state_t      state_q, state_d;
  logic [5:0]  j_q, j_d;
  logic [2:0]  m_q, m_d;
  logic [3:0]  nk_q, nk_d;
  logic [3:0]  nr_q, nr_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        err_q, err_d;
  logic        kr_q, kr_d;
  logic [31:0] w_q [NWORDS];
  logic [31:0] w_d [NWORDS];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 by repeated squaring, then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rd_word(input logic [5:0] a);
    return (a < NWORDS_W) ? w_q[a] : 32'h0;
  endfunction

  logic [3:0] req_nk, req_nr;
  logic       req_ok;

  always_comb begin
    req_nk = 4'd0;
    req_nr = 4'd0;
    case (key_len)
      2'b00:   begin req_nk = 4'd4; req_nr = 4'd10; end
      2'b01:   begin req_nk = 4'd6; req_nr = 4'd12; end
      2'b10:   begin req_nk = 4'd8; req_nr = 4'd14; end
      default: begin req_nk = 4'd0; req_nr = 4'd0;  end
    endcase
    req_ok = (key_len != 2'b11) && (req_nk <= MAX_NK_W);
  end

  // m_q tracks j mod Nk so no divider is needed.
  logic [31:0] prev_w, old_w, sub_in, sub_out, temp_w, new_w;
  logic [5:0]  last_j;

  always_comb begin
    prev_w  = rd_word(j_q - 6'd1);
    old_w   = rd_word(j_q - {2'b00, nk_q});
    sub_in  = (m_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (m_q == 3'd0)                       temp_w = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && m_q == 3'd4)  temp_w = sub_out;
    else                                   temp_w = prev_w;
    new_w  = old_w ^ temp_w;
    last_j = {nr_q + 4'd1, 2'b00} - 6'd1;
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    m_d     = m_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    rcon_d  = rcon_q;
    err_d   = 1'b0;
    kr_d    = kr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          kr_d = 1'b0;
          if (req_ok) begin
            nk_d    = req_nk;
            nr_d    = req_nr;
            j_d     = {2'b00, req_nk};
            m_d     = 3'd0;
            rcon_d  = 8'h01;
            state_d = EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EXPAND: begin
        j_d = j_q + 6'd1;
        m_d = ({1'b0, m_q} == nk_q - 4'd1) ? 3'd0 : m_q + 3'd1;
        if (m_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (j_q == last_j) begin
          state_d = FINISH;
          kr_d    = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NWORDS; i++) w_d[i] = w_q[i];
    if (state_q == IDLE && start && req_ok) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(req_nk)) w_d[k] = key_in[255-32*k -: 32];
      end
    end else if (state_q == EXPAND) begin
      w_d[j_q] = new_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      j_q     <= 6'd0;
      m_q     <= 3'd0;
      nk_q    <= 4'd0;
      nr_q    <= 4'd0;
      rcon_q  <= 8'h01;
      err_q   <= 1'b0;
      kr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      m_q     <= m_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      rcon_q  <= rcon_d;
      err_q   <= err_d;
      kr_q    <= kr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NWORDS; i++) w_q[i] <= w_d[i];
  end

  logic [5:0] rk_base;

  always_comb begin
    rk_base = {rk_idx, 2'b00};
    rk_out  = '0;
    if (kr_q && rk_idx <= nr_q) begin
      rk_out = {rd_word(rk_base), rd_word(rk_base + 6'd1),
                rd_word(rk_base + 6'd2), rd_word(rk_base + 6'd3)};
    end
  end

  assign busy      = (state_q == EXPAND);
  assign done      = (state_q == FINISH);
  assign err       = err_q;
  assign key_ready = kr_q;

endmodule

// File: tb/tb_key_expander_iter.sv
// tb/tb_key_expander_iter.sv - self-checking bench for key_expander_iter
// FIPS-197 style schedule model plus a per-cycle output monitor.
module tb_key_expander_iter;
  typedef logic [59:0][31:0] words_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key_in = '0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy, done, err, key_ready;
  logic [127:0] rk_out;
  logic         busy4, done4, err4, key_ready4;
  logic [127:0] rk_out4;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_expander_iter #(.MAX_NK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .rk_idx(rk_idx), .busy(busy), .done(done), .err(err), .key_ready(key_ready), .rk_out(rk_out)
  );

  key_expander_iter #(.MAX_NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .rk_idx(rk_idx), .busy(busy4), .done(done4), .err(err4), .key_ready(key_ready4), .rk_out(rk_out4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_tab(input int i);
    case (i)
      0: return 8'h01;  1: return 8'h02;  2: return 8'h04;  3: return 8'h08;
      4: return 8'h10;  5: return 8'h20;  6: return 8'h40;  7: return 8'h80;
      8: return 8'h1b;  default: return 8'h36;
    endcase
  endfunction

  function automatic words_t expand(input logic [255:0] key, input int nk, input int nr);
    words_t w = '0;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab(i/nk - 1), 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    return w;
  endfunction

  function automatic int mode_nk(input logic [1:0] kl);
    return (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
  endfunction

  // Model: countdown of remaining schedule words; results become visible at completion.
  logic   m_busy = 0, m_done = 0, m_err = 0, m_ready = 0;
  int     m_left = 0;
  int     m_nr = 0, p_nr = 0;
  words_t m_words = '0, p_words = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_err <= 0; m_ready <= 0; m_left <= 0;
    end else begin
      m_err  <= 0;
      m_done <= 0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 0; m_done <= 1; m_ready <= 1; m_words <= p_words; m_nr <= p_nr;
        end
      end else if (!m_done && start) begin
        m_ready <= 0;
        if (key_len == 2'b11) m_err <= 1;
        else begin
          m_left  <= 4*(mode_nk(key_len) + 7) - mode_nk(key_len);
          m_busy  <= 1;
          p_words <= expand(key_in, mode_nk(key_len), mode_nk(key_len) + 6);
          p_nr    <= mode_nk(key_len) + 6;
        end
      end
    end
  end

  function automatic logic [127:0] exp_rk(input int idx);
    if (!m_ready || idx > m_nr) return '0;
    return {m_words[4*idx], m_words[4*idx+1], m_words[4*idx+2], m_words[4*idx+3]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("err", err, m_err);
      check("key_ready", key_ready, m_ready);
      check("rk_out", rk_out, exp_rk(int'(rk_idx)));
    end
  end

  task automatic run(input logic [1:0] kl, input logic [255:0] key, input int exp_edges, input bit poke);
    int n;
    @(posedge clk); #1;
    key_len = kl; key_in = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_in = ~key; key_len = 2'b11;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (n == 0 && kl != 2'b00) begin
        check("nk4_err", err4, 1'b1);
        check("nk4_busy", busy4, 1'b0);
      end
      if (done) break;
      start = poke && (n == 10 || n == 11);
    end
    start = 1'b0;
    check("latency", n, exp_edges);
    if (kl == 2'b00) check("nk4_done", done4, 1'b1);
  endtask

  task automatic read_rk(input int idx);
    @(posedge clk); #1;
    rk_idx = 4'(idx);
    @(negedge clk);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) read_rk(i);
  endtask

  initial begin
    logic [7:0] inv, s, c;
    words_t mw;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = s;
    end
    check("model_sbox53", sb[8'h53], 8'hed);
    mw = expand(K128, 4, 10);
    check("model_w43", mw[43], 32'hb6630ca6);
    mw = expand(K256, 8, 14);
    check("model_w59", mw[59], 32'h706c631e);
    chk_en = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rk", rk_out, '0);
    check("reset_ready", key_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(2'b00, K128, 40, 1'b0);
    sweep();
    read_rk(10);
    check("aes128_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("nk4_rk10", rk_out4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    @(posedge clk); #1;
    key_len = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("illegal_err", err, 1'b1);
    check("illegal_busy", busy, 1'b0);
    check("illegal_ready", key_ready, 1'b0);
    check("illegal_err4", err4, 1'b1);
    @(negedge clk);
    check("illegal_err_pulse", err, 1'b0);

    run(2'b01, K192, 46, 1'b0);
    sweep();
    read_rk(12);
    check("aes192_w51", rk_out[31:0], 32'h01002202);

    run(2'b10, K256, 52, 1'b1);
    sweep();
    read_rk(14);
    check("aes256_w59", rk_out[31:0], 32'h706c631e);
    read_rk(15);
    check("aes256_rk15", rk_out, '0);

    @(posedge clk); #1;
    key_len = 2'b00; key_in = K128; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_ready", key_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(2'b00, K128, 40, 1'b0);
    read_rk(10);
    check("rerun_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
